// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback over one shared memory port with a ready handshake.
module multicycle_ctrl #(
    parameter int WIDTH = 32,
    parameter int ALU_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr,
    input  logic             EQ,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCsrc,
    output logic             RegWrite,
    output logic             ResultSrc,
    output logic             ALUsrc,
    output logic [ALU_W-1:0] ALUctrl,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       state,
    output logic             illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } stateT;

    localparam logic [ALU_W-1:0] ALU_ADD = '0;
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);

    stateT stateReg, stateNext;
    logic  illegalReg, illegalNext;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       isAddi, isAdd, isSub, isLw, isSw, isBeq, isBne, isBranch, isLegal;
    logic       unusedBits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // rd/rs fields are consumed by the datapath, not by the controller
    assign unusedBits = ^{instr[24:15], instr[11:7]};

    assign isAddi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign isAdd    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign isSub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign isLw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign isSw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign isBeq    = (opcode == 7'b1100011) && (funct3 == 3'b000);
    assign isBne    = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign isBranch = isBeq | isBne;
    assign isLegal  = isAddi | isAdd | isSub | isLw | isSw | isBranch;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= FETCH;
            illegalReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            illegalReg <= illegalNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        illegalNext = illegalReg;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCsrc       = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 1'b0;
        ALUsrc      = 1'b0;
        ALUctrl     = ALU_ADD;
        ImmSrc      = 2'b00;
        state       = stateReg;
        illegal     = illegalReg;

        // ALU/immediate controls are held steady from EXEC through MEM and WB
        if (stateReg == EXEC || stateReg == MEM || stateReg == WB) begin
            ALUsrc  = isAddi | isLw | isSw;
            ALUctrl = (isSub | isBranch) ? ALU_SUB : ALU_ADD;
            if (isSw) begin
                ImmSrc = 2'b01;
            end else if (isBranch) begin
                ImmSrc = 2'b10;
            end
        end

        case (stateReg)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    stateNext = DECODE;
                end
            end
            DECODE: begin
                if (isLegal) begin
                    stateNext = EXEC;
                end else begin
                    illegalNext = 1'b1;
                    stateNext   = HALT;
                end
            end
            EXEC: begin
                if (isBranch) begin
                    PCWrite   = 1'b1;
                    PCsrc     = isBeq ? EQ : ~EQ;
                    stateNext = FETCH;
                end else if (isLw || isSw) begin
                    stateNext = MEM;
                end else begin
                    stateNext = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = isSw;
                if (mem_ready) begin
                    if (isSw) begin
                        PCWrite   = 1'b1;
                        stateNext = FETCH;
                    end else begin
                        stateNext = WB;
                    end
                end
            end
            WB: begin
                RegWrite  = 1'b1;
                ResultSrc = isLw;
                PCWrite   = 1'b1;
                stateNext = FETCH;
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase

        // Reset masks every output combinationally, abandoning any in-flight access
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            PCsrc     = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = 1'b0;
            ALUsrc    = 1'b0;
            ALUctrl   = ALU_ADD;
            ImmSrc    = 2'b00;
            state     = 3'd0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: per-cycle expected output vectors per scenario.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        EQ = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc, ALUsrc;
    logic [2:0]  ALUctrl;
    logic [1:0]  ImmSrc;
    logic [2:0]  state;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl #(.WIDTH(32), .ALU_W(3)) dut (
        .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCsrc(PCsrc), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUsrc(ALUsrc),
        .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {state, req, we, irw, pcw, pcs, rw, rs, asrc, aluctrl, immsrc, illegal}
    logic [16:0] obs;
    assign obs = {state, mem_req, mem_we, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc,
                  ALUsrc, ALUctrl, ImmSrc, illegal};

    // strb = {req, we, irw, pcw, pcs, rw, rs, asrc}
    function automatic logic [16:0] ex(input logic [2:0] st, input logic [7:0] strb,
                                       input logic [2:0] actrl, input logic [1:0] imm,
                                       input logic ill);
        return {st, strb, actrl, imm, ill};
    endfunction

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BEQ  = 32'h00208463;

    task automatic test_reset();
        logic [16:0] expV [3];
        logic        rstV [3];
        logic        rdyV [3];
        expV = '{17'h0, 17'h0, ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0)};
        rstV = '{1'b1, 1'b1, 1'b0};
        rdyV = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            rst = rstV[i];
            mem_ready = rdyV[i];
            @(negedge clk);
            checks++;
            if (obs !== expV[i]) begin
                failures++;
                $display("FAIL reset cycle %0d: got=%h expected=%h", i, obs, expV[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
        logic [16:0] expV [5];
        logic        rdyV [5];
        instr = I_ADDI;
        expV = '{ex(3'd0, 8'b1010_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd1, 8'b0000_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd2, 8'b0000_0001, 3'd0, 2'b00, 1'b0),
                 ex(3'd4, 8'b0001_0101, 3'd0, 2'b00, 1'b0),
                 ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0)};
        rdyV = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdyV[i];
            @(negedge clk);
            checks++;
            if (obs !== expV[i]) begin
                failures++;
                $display("FAIL addi cycle %0d: got=%h expected=%h", i + 1, obs, expV[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add_sub();
        logic [16:0] expV [5];
        for (int r = 0; r < 2; r++) begin
            instr = (r == 0) ? I_ADD : I_SUB;
            expV = '{ex(3'd0, 8'b1010_0000, 3'd0, 2'b00, 1'b0),
                     ex(3'd1, 8'b0000_0000, 3'd0, 2'b00, 1'b0),
                     ex(3'd2, 8'b0000_0000, 3'(r), 2'b00, 1'b0),
                     ex(3'd4, 8'b0001_0100, 3'(r), 2'b00, 1'b0),
                     ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0)};
            for (int i = 0; i < 5; i++) begin
                mem_ready = (i < 4);
                @(negedge clk);
                checks++;
                if (obs !== expV[i]) begin
                    failures++;
                    $display("FAIL %s cycle %0d: got=%h expected=%h",
                             (r == 0) ? "add" : "sub", i + 1, obs, expV[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [16:0] expV [9];
        logic        rdyV [9];
        instr = I_LW;
        expV = '{ex(3'd0, 8'b1010_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd1, 8'b0000_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd2, 8'b0000_0001, 3'd0, 2'b00, 1'b0),
                 ex(3'd3, 8'b1000_0001, 3'd0, 2'b00, 1'b0),
                 ex(3'd3, 8'b1000_0001, 3'd0, 2'b00, 1'b0),
                 ex(3'd3, 8'b1000_0001, 3'd0, 2'b00, 1'b0),
                 ex(3'd3, 8'b1000_0001, 3'd0, 2'b00, 1'b0),
                 ex(3'd4, 8'b0001_0111, 3'd0, 2'b00, 1'b0),
                 ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0)};
        rdyV = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdyV[i];
            @(negedge clk);
            checks++;
            if (obs !== expV[i]) begin
                failures++;
                $display("FAIL lw cycle %0d: got=%h expected=%h", i + 1, obs, expV[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        logic [16:0] expV [6];
        logic        rdyV [6];
        instr = I_SW;
        expV = '{ex(3'd0, 8'b1010_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd1, 8'b0000_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd2, 8'b0000_0001, 3'd0, 2'b01, 1'b0),
                 ex(3'd3, 8'b1100_0001, 3'd0, 2'b01, 1'b0),
                 ex(3'd3, 8'b1101_0001, 3'd0, 2'b01, 1'b0),
                 ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0)};
        rdyV = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdyV[i];
            @(negedge clk);
            checks++;
            if (obs !== expV[i]) begin
                failures++;
                $display("FAIL sw cycle %0d: got=%h expected=%h", i + 1, obs, expV[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [31:0] instrV [4];
        logic        eqV [4];
        logic        takenV [4];
        logic [16:0] expV [4];
        instrV = '{I_BNE, I_BNE, I_BEQ, I_BEQ};
        eqV    = '{1'b0, 1'b1, 1'b1, 1'b0};
        takenV = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int r = 0; r < 4; r++) begin
            instr = instrV[r];
            EQ = eqV[r];
            expV = '{ex(3'd0, 8'b1010_0000, 3'd0, 2'b00, 1'b0),
                     ex(3'd1, 8'b0000_0000, 3'd0, 2'b00, 1'b0),
                     ex(3'd2, {4'b0001, takenV[r], 3'b000}, 3'd1, 2'b10, 1'b0),
                     ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0)};
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i < 3);
                @(negedge clk);
                checks++;
                if (obs !== expV[i]) begin
                    failures++;
                    $display("FAIL branch run %0d EQ=%0b cycle %0d: got=%h expected=%h",
                             r, eqV[r], i + 1, obs, expV[i]);
                end
                @(posedge clk); #1;
            end
        end
        EQ = 1'b0;
    endtask

    task automatic test_illegal();
        logic [16:0] expV [7];
        logic        rdyV [7];
        logic        rstV [7];
        instr = 32'hFFFFFFFF;
        expV = '{ex(3'd0, 8'b1010_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd1, 8'b0000_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd7, 8'b0000_0000, 3'd0, 2'b00, 1'b1),
                 ex(3'd7, 8'b0000_0000, 3'd0, 2'b00, 1'b1),
                 ex(3'd7, 8'b0000_0000, 3'd0, 2'b00, 1'b1),
                 17'h0,
                 ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0)};
        rdyV = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rstV = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdyV[i];
            rst = rstV[i];
            @(negedge clk);
            checks++;
            if (obs !== expV[i]) begin
                failures++;
                $display("FAIL illegal cycle %0d: got=%h expected=%h", i + 1, obs, expV[i]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] instrV [10];
        logic [16:0] expV [10];
        logic        rdyV [10];
        logic        rstV [10];
        instrV = '{I_ADDI, I_ADDI, I_ADDI, I_ADDI, I_SW, I_SW, I_SW, I_SW, I_SW, I_SW};
        expV = '{ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0),
                 17'h0,
                 ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd0, 8'b1010_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd1, 8'b0000_0000, 3'd0, 2'b00, 1'b0),
                 ex(3'd2, 8'b0000_0001, 3'd0, 2'b01, 1'b0),
                 ex(3'd3, 8'b1100_0001, 3'd0, 2'b01, 1'b0),
                 17'h0,
                 ex(3'd0, 8'b1000_0000, 3'd0, 2'b00, 1'b0)};
        rdyV = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rstV = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            instr = instrV[i];
            mem_ready = rdyV[i];
            rst = rstV[i];
            @(negedge clk);
            checks++;
            if (obs !== expV[i]) begin
                failures++;
                $display("FAIL reset_mid_wait cycle %0d: got=%h expected=%h", i + 1, obs, expV[i]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add_sub();
        test_lw_wait();
        test_sw();
        test_branch();
        test_illegal();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I-subset datapath (PC, IR, register file, ALU, immediate extender, shared instruction/data memory). Sequences fetch/decode/execute/memory/writeback. Drives ImmSrc for the immediate extender, ALU controls, and register-file/memory strobes. Supports one shared memory port with a ready handshake (variable wait states).

Parameters:
WIDTH, 32, instruction/data width
ALU_W, 3, ALUctrl width

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
instr  in  WIDTH  current IR contents (opcode[6:0], funct3[14:12], funct7[31:25])
EQ  in  1  ALU equal flag (operands equal), valid combinationally in EXEC
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write enable (only with mem_req)
IRWrite  out  1  load IR from memory read data at this edge
PCWrite  out  1  update PC at this edge
PCsrc  out  1  0: PC+4, 1: PC+ImmOp
RegWrite  out  1  write rd at this edge
ResultSrc  out  1  0: ALU result, 1: memory read data
ALUsrc  out  1  0: rs2, 1: ImmOp
ALUctrl  out  ALU_W  000 add, 001 sub
ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type
state  out  3  debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7
illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Registered state; outputs combinational from state, instr, EQ, mem_ready. Unlisted outputs are 0 in every state.
- Reset: while rst=1 all outputs 0 (state reads 0). On the next edge: state=FETCH, illegal=0. Reset overrides any state, including mid-wait in FETCH/MEM; the pending request is abandoned.
- Decoded ops:
  - addi: 0010011, f3=000.
  - add: 0110011, f3=000, f7=0000000.
  - sub: 0110011, f3=000, f7=0100000.
  - lw: 0000011, f3=010.
  - sw: 0100011, f3=010.
  - beq: 1100011, f3=000.
  - bne: 1100011, f3=001.
  - Anything else is illegal.
- FETCH: mem_req=1, mem_we=0. If mem_ready=0, hold. If mem_ready=1, IRWrite=1 and go to DECODE.
- DECODE: one cycle, no strobes. Illegal op: set illegal=1 and go to HALT. Otherwise go to EXEC.
- EXEC:
  - addi: ALUsrc=1, ImmSrc=00, ALUctrl=000; go to WB.
  - add/sub: ALUsrc=0, ALUctrl=000/001; go to WB.
  - lw: ALUsrc=1, ImmSrc=00, ALUctrl=000; go to MEM.
  - sw: same controls but ImmSrc=01; go to MEM.
  - beq/bne: ALUsrc=0, ALUctrl=001, ImmSrc=10, PCWrite=1. PCsrc=EQ for beq, ~EQ for bne. Go to FETCH.
- MEM: mem_req=1, mem_we=1 for sw; ALU controls held as in EXEC. If mem_ready=0, hold.
  - sw with mem_ready=1: PCWrite=1, PCsrc=0; go to FETCH.
  - lw with mem_ready=1: go to WB.
- WB: RegWrite=1, ResultSrc=1 for lw, else 0. ALU controls held as in EXEC. PCWrite=1, PCsrc=0. Go to FETCH.
  - rd=x0 is not special-cased; the register file discards the write.
- HALT: all strobes 0, illegal=1. Exits only on rst.
- mem_ready outside FETCH/MEM is ignored. mem_ready seen in the first cycle of FETCH/MEM means a zero-wait access.
- Latency with zero-wait memory:
  - addi/add/sub: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - Each wait cycle adds 1.
- PCWrite is asserted exactly once per retired instruction. IRWrite is asserted exactly once per fetch.

Test Plan:
- Reset, then instr=0x00500093 (addi x1,x0,5) with mem_ready=1 always -> state sequence 0,1,2,4,0. IRWrite pulses in cycle 1, RegWrite+PCWrite in cycle 4, ImmSrc=00, ALUsrc=1.
- lw 0x0000A103 with mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles with mem_req=1, mem_we=0. Then WB with ResultSrc=1, RegWrite=1. Total 8 cycles.
- sw 0x0020A023 -> EXEC ImmSrc=01. MEM shows mem_req=mem_we=1. PCWrite with PCsrc=0 on the ready cycle. RegWrite never asserted.
- bne 0x00209463, two runs: EQ=0 gives EXEC PCWrite=1, PCsrc=1; EQ=1 gives PCsrc=0. Both use ALUctrl=001, ImmSrc=10, and 3 cycles total.
- instr=0xFFFFFFFF -> DECODE goes to HALT, illegal=1, no PCWrite. mem_ready pulses ignored. rst clears illegal and the next cycle is FETCH.
- Assert rst during a FETCH wait and during a MEM wait of sw -> mem_req/mem_we drop to 0 in the rst cycle. Next cycle state=FETCH, mem_we=0, no spurious PCWrite/RegWrite.
